// File: rtl/sp_frame_pkt_if.sv
// Stream bundle between the readout stage, the framer and the host link:
// the packed-pixel input words plus the valid/ready/last packet stream.
interface sp_frame_pkt_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    // Framer side: consumes pixel words, produces the packet stream.
    modport slave (
        input  in_data, in_valid, m_ready,
        output m_data, m_valid, m_last
    );

    // Environment side: supplies pixel words, consumes the packet stream.
    modport master (
        output in_data, in_valid, m_ready,
        input  m_data, m_valid, m_last
    );
endinterface

// File: rtl/sp_frame_pkt.sv
// Frame packetiser: buffers packed-pixel words in a FIFO and wraps each sensor
// frame as header / data / trailer on a valid-ready stream. Words that cannot
// be stored are dropped and counted. If the dropped word closes a frame, an
// end-of-frame marker entry is queued later so packet boundaries never slip.
module sp_frame_pkt #(
    parameter int          FIFO_DEPTH      = 1024,
    parameter int          WORDS_PER_FRAME = 4096,
    parameter logic [15:0] HDR_SYNC        = 16'hA5A5,
    parameter logic [7:0]  TRL_SYNC        = 8'h5A
) (
    input  logic                          clk,
    input  logic                          rst,
    sp_frame_pkt_if.slave                 bus,
    output logic [15:0]                   frame_cnt,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0]    LAST_IDX = 16'(WORDS_PER_FRAME - 1);
    localparam logic [AW:0]    FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_TRL} state_t;

    state_t         state_reg, state_next;

    // Entry layout: {eof, marker, data}
    logic [33:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;

    logic [15:0]    in_cnt_reg;
    logic [15:0]    sent_cnt_reg;
    logic           pend_eof_reg, pend_eof_next;
    logic           frame_err_reg;
    // Drops seen while a trailer is stalled; folded into frame_err after it
    // leaves, so the trailer word stays stable during the stall.
    logic           err_hold_reg;

    logic [33:0]    head;
    logic           fifo_empty, fifo_full, space, is_eof;
    logic           push_marker, push_word, push, drop;
    logic [33:0]    push_data;
    logic           pop, sent_clr, sent_inc, trl_xfer;

    assign head       = mem[rd_ptr_reg];
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == FULL_LVL);

    // Input side: decide push / marker push / drop; a same-cycle pop frees a slot.
    always_comb begin
        space         = !fifo_full || pop;
        is_eof        = (in_cnt_reg == LAST_IDX);
        push_marker   = pend_eof_reg && space;
        push_word     = !pend_eof_reg && bus.in_valid && space;
        push          = push_marker || push_word;
        drop          = bus.in_valid && (pend_eof_reg || !space);
        push_data     = push_marker ? {2'b11, 32'h0} : {is_eof, 1'b0, bus.in_data};
        pend_eof_next = pend_eof_reg;
        if (push_marker) begin
            pend_eof_next = 1'b0;
        end
        if (drop && is_eof) begin
            pend_eof_next = 1'b1;
        end
    end

    // Output FSM: next state, stream outputs and FIFO pop.
    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        sent_clr    = 1'b0;
        sent_inc    = 1'b0;
        trl_xfer    = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_data  = '0;
        bus.m_last  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                bus.m_valid = 1'b1;
                bus.m_data  = {HDR_SYNC, frame_cnt};
                if (bus.m_ready) begin
                    sent_clr   = 1'b1;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (!fifo_empty && head[32]) begin
                    // Marker: frame ended with dropped words; consume silently.
                    pop        = 1'b1;
                    state_next = S_TRL;
                end else begin
                    bus.m_valid = !fifo_empty;
                    bus.m_data  = head[31:0];
                    if (!fifo_empty && bus.m_ready) begin
                        pop      = 1'b1;
                        sent_inc = 1'b1;
                        if (head[33]) begin
                            state_next = S_TRL;
                        end
                    end
                end
            end
            S_TRL: begin
                bus.m_valid = 1'b1;
                bus.m_last  = 1'b1;
                bus.m_data  = {TRL_SYNC, 7'b0, frame_err_reg, sent_cnt_reg};
                if (bus.m_ready) begin
                    trl_xfer   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FIFO storage write; left without reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            fifo_level <= fifo_level + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // Input word position, pending marker and drop statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt_reg   <= '0;
            pend_eof_reg <= 1'b0;
            overflow     <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            if (bus.in_valid) begin
                in_cnt_reg <= is_eof ? 16'd0 : in_cnt_reg + 16'd1;
            end
            pend_eof_reg <= pend_eof_next;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

    // Per-frame error flag; a drop during a trailer flags the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_reg <= 1'b0;
            err_hold_reg  <= 1'b0;
        end else if (state_reg == S_TRL) begin
            if (trl_xfer) begin
                frame_err_reg <= drop || err_hold_reg;
                err_hold_reg  <= 1'b0;
            end else if (drop) begin
                err_hold_reg <= 1'b1;
            end
        end else if (drop) begin
            frame_err_reg <= 1'b1;
        end
    end

    // FSM state, data-word count and completed-packet count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            sent_cnt_reg <= '0;
            frame_cnt    <= '0;
        end else begin
            state_reg <= state_next;
            if (sent_clr) begin
                sent_cnt_reg <= '0;
            end else if (sent_inc) begin
                sent_cnt_reg <= sent_cnt_reg + 16'd1;
            end
            if (trl_xfer) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_sp_frame_pkt.sv
// Scoreboard bench for sp_frame_pkt: three instances with different sizes.
// Stimulus pushes the expected beats; a monitor thread checks every transfer.
`timescale 1ns/1ps
module tb_sp_frame_pkt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sp_frame_pkt_if if_a ();
    sp_frame_pkt_if if_b ();
    sp_frame_pkt_if if_c ();

    logic [15:0] fc_a, fc_b, fc_c, dc_a, dc_b, dc_c;
    logic        ov_a, ov_b, ov_c;
    logic [4:0]  lvl_a, lvl_c;
    logic [2:0]  lvl_b;

    sp_frame_pkt #(.FIFO_DEPTH(16), .WORDS_PER_FRAME(8)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a),
        .frame_cnt(fc_a), .overflow(ov_a), .drop_cnt(dc_a), .fifo_level(lvl_a));
    sp_frame_pkt #(.FIFO_DEPTH(4), .WORDS_PER_FRAME(8)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b),
        .frame_cnt(fc_b), .overflow(ov_b), .drop_cnt(dc_b), .fifo_level(lvl_b));
    sp_frame_pkt #(.FIFO_DEPTH(16), .WORDS_PER_FRAME(1)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c),
        .frame_cnt(fc_c), .overflow(ov_c), .drop_cnt(dc_c), .fifo_level(lvl_c));

    int          total = 0;
    int          bad   = 0;
    int          xfer [3];
    logic [32:0] exp_q [3][$];
    logic        prev_v [3];
    logic        prev_r [3];
    logic [32:0] prev_d [3];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One monitor sample for instance i (called on the falling edge).
    task automatic mon(int i, logic v, logic r, logic l, logic [31:0] d);
        logic [32:0] e;
        if (rst) begin
            prev_v[i] = 1'b0;
        end else begin
            if (prev_v[i] && !prev_r[i]) begin
                total++;
                if (!v || {l, d} !== prev_d[i]) begin
                    bad++;
                    $display("FAIL stall%0d: got v=%0b %09h expected v=1 %09h", i, v, {l, d}, prev_d[i]);
                end
            end
            if (v && r) begin
                xfer[i]++;
                total++;
                if (exp_q[i].size() == 0) begin
                    bad++;
                    $display("FAIL beat%0d: got %09h expected none", i, {l, d});
                end else begin
                    e = exp_q[i].pop_front();
                    if ({l, d} !== e) begin
                        bad++;
                        $display("FAIL beat%0d: got %09h expected %09h", i, {l, d}, e);
                    end else begin
                        $display("dut%0d beat data=%08h last=%0b", i, d, l);
                    end
                end
            end
            prev_v[i] = v;
            prev_r[i] = r;
            prev_d[i] = {l, d};
        end
    endtask

    task automatic drive(int i, logic v, logic [31:0] d, logic r);
        case (i)
            0: begin if_a.in_valid = v; if_a.in_data = d; if_a.m_ready = r; end
            1: begin if_b.in_valid = v; if_b.in_data = d; if_b.m_ready = r; end
            default: begin if_c.in_valid = v; if_c.in_data = d; if_c.m_ready = r; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pkt(int i, logic [15:0] fc, logic [31:0] base, int n, logic [31:0] trl);
        exp_q[i].push_back({1'b0, 16'hA5A5, fc});
        for (int k = 0; k < n; k++) begin
            exp_q[i].push_back({1'b0, base + 32'(k)});
        end
        exp_q[i].push_back({1'b1, trl});
    endtask

    task automatic send_frame(int i, logic [31:0] base, int n, logic r);
        for (int k = 0; k < n; k++) begin
            drive(i, 1'b1, base + 32'(k), r);
            step();
        end
        drive(i, 1'b0, 32'h0, r);
    endtask

    task automatic wait_drain(int i, string name);
        for (int k = 0; k < 400; k++) begin
            if (exp_q[i].size() == 0) break;
            step();
        end
        chk(name, 32'(exp_q[i].size()), 32'd0);
    endtask

    initial begin
        int start;
        for (int i = 0; i < 3; i++) begin
            xfer[i] = 0;
            prev_v[i] = 1'b0;
            prev_r[i] = 1'b0;
            prev_d[i] = '0;
            drive(i, 1'b0, 32'h0, 1'b0);
        end
        fork
            forever begin
                @(negedge clk);
                mon(0, if_a.m_valid, if_a.m_ready, if_a.m_last, if_a.m_data);
                mon(1, if_b.m_valid, if_b.m_ready, if_b.m_last, if_b.m_data);
                mon(2, if_c.m_valid, if_c.m_ready, if_c.m_last, if_c.m_data);
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(if_a.m_valid), 32'd0);
        chk("rst_data", if_a.m_data, 32'd0);
        chk("rst_last", 32'(if_a.m_last), 32'd0);
        chk("rst_fcnt", 32'(fc_a), 32'd0);
        chk("rst_ovf", 32'(ov_a), 32'd0);
        chk("rst_drop", 32'(dc_b), 32'd0);
        chk("rst_lvl", 32'(lvl_c), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Basic packet
        exp_pkt(0, 16'd0, 32'd1, 8, 32'h5A00_0008);
        send_frame(0, 32'd1, 8, 1'b1);
        wait_drain(0, "basic_drain");
        chk("basic_fcnt", 32'(fc_a), 32'd1);
        chk("basic_drop", 32'(dc_a), 32'd0);
        chk("basic_lvl", 32'(lvl_a), 32'd0);

        // Backpressure: m_ready toggles every cycle
        exp_pkt(0, 16'd1, 32'd21, 8, 32'h5A00_0008);
        for (int k = 0; k < 60; k++) begin
            drive(0, k < 8, 32'd21 + 32'(k), (k % 2) == 0);
            step();
            if (k >= 8 && exp_q[0].size() == 0) break;
        end
        drive(0, 1'b0, 32'h0, 1'b1);
        wait_drain(0, "bp_drain");
        chk("bp_fcnt", 32'(fc_a), 32'd2);
        chk("bp_drop", 32'(dc_a), 32'd0);
        chk("bp_ovf", 32'(ov_a), 32'd0);

        // Overflow: depth 4, consumer stalled until all 8 words offered
        exp_pkt(1, 16'd0, 32'd1, 4, 32'h5A01_0004);
        send_frame(1, 32'd1, 8, 1'b0);
        chk("ovf_flag", 32'(ov_b), 32'd1);
        chk("ovf_drop", 32'(dc_b), 32'd4);
        chk("ovf_full_lvl", 32'(lvl_b), 32'd4);

        // Late marker: words offered on the header cycle and the first pop cycle
        drive(1, 1'b1, 32'hDEAD_0000, 1'b1);
        step();
        drive(1, 1'b1, 32'hDEAD_0001, 1'b1);
        step();
        drive(1, 1'b0, 32'h0, 1'b1);
        wait_drain(1, "ovf_drain");
        chk("late_drop", 32'(dc_b), 32'd6);
        chk("late_fcnt", 32'(fc_b), 32'd1);
        exp_pkt(1, 16'd1, 32'd41, 6, 32'h5A00_0006);
        send_frame(1, 32'd41, 6, 1'b1);
        wait_drain(1, "late_drain");
        chk("late_fcnt2", 32'(fc_b), 32'd2);
        chk("late_ovf", 32'(ov_b), 32'd1);

        // Reset mid-packet after three data words
        exp_pkt(0, 16'd2, 32'd51, 8, 32'h5A00_0008);
        send_frame(0, 32'd51, 8, 1'b0);
        start = xfer[0];
        drive(0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 100; k++) begin
            if (xfer[0] - start >= 4) break;
            step();
        end
        chk("mid_beats", 32'(xfer[0] - start), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_valid", 32'(if_a.m_valid), 32'd0);
        chk("mid_data", if_a.m_data, 32'd0);
        chk("mid_last", 32'(if_a.m_last), 32'd0);
        chk("mid_fcnt", 32'(fc_a), 32'd0);
        chk("mid_lvl", 32'(lvl_a), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        step();
        exp_pkt(0, 16'd0, 32'd61, 8, 32'h5A00_0008);
        send_frame(0, 32'd61, 8, 1'b1);
        wait_drain(0, "mid_drain");
        chk("mid_fcnt2", 32'(fc_a), 32'd1);

        // Wrap: 16 single-word frames
        for (int f = 0; f < 16; f++) begin
            exp_pkt(2, 16'(f), 32'd100 + 32'(f), 1, 32'h5A00_0001);
        end
        send_frame(2, 32'd100, 16, 1'b1);
        wait_drain(2, "wrap_drain");
        chk("wrap_fcnt", 32'(fc_c), 32'd16);
        chk("wrap_drop", 32'(dc_c), 32'd0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
